ads1675_frame_rx: RTL and testbench

- Synchronous serial receiver for the ADS1675 24-bit delta-sigma ADC. It captures one sample per conversion in the aclk domain.
- Samples DRDY, SCLK and DOUT through synchronizers and shifts DOUT MSB-first on SCLK falling edges.
- Discards the first frames after enable (the lock DRDY plus the settling frames), then buffers samples in a small FIFO.
- Presents samples to downstream processing as sign-extended words on a valid/ready stream.

---
 rtl/ads1675_frame_rx_if.sv | 21 ++
 rtl/ads1675_frame_rx.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ads1675_frame_rx.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads1675_frame_rx_if.sv
// Sample stream between the ADS1675 frame receiver and downstream processing.
// The master drives data/valid and the slave drives ready.
interface ads1675_frame_rx_if #(
  parameter int unsigned OUT_W = 32
) ();
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/ads1675_frame_rx.sv
// ADS1675 serial frame receiver. Oversamples DRDY/SCLK/DOUT in the aclk domain,
// shifts DW bits MSB-first per frame, drops the startup frames after enable and
// queues sign-extended samples in a first-word-fall-through FIFO.
module ads1675_frame_rx #(
  parameter int unsigned DW          = 24,
  parameter int unsigned OUT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DISCARD     = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     en,
  input  logic                     sclk,
  input  logic                     dout,
  input  logic                     drdy,
  ads1675_frame_rx_if.master       m_axis,
  output logic                     overflow,
  output logic                     frame_err,
  output logic                     discarding
);

  localparam int unsigned CntW  = $clog2(DW + 1);
  localparam int unsigned DiscW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ExtW  = OUT_W - DW;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitDrdy = 2'd1,
    StShift    = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_drdy_sync;
  logic [SYNC_STAGES-1:0] r_dout_sync;
  logic                   r_sclk_prev;
  logic                   r_drdy_prev;
  logic                   w_sclk_s;
  logic                   w_drdy_s;
  logic                   w_dout_s;
  logic                   w_sclk_fall;
  logic                   w_drdy_rise;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_drdy_s    = r_drdy_sync[SYNC_STAGES-1];
  assign w_dout_s    = r_dout_sync[SYNC_STAGES-1];
  assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;
  assign w_drdy_rise = ~r_drdy_prev & w_drdy_s;

  // Multi-flop synchronizers; sclk/drdy get one more copy to detect edges
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_sclk_sync <= '0;
      r_drdy_sync <= '0;
      r_dout_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_drdy_prev <= 1'b0;
    end else begin
      r_sclk_sync[0] <= sclk;
      r_drdy_sync[0] <= drdy;
      r_dout_sync[0] <= dout;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_drdy_sync[i] <= r_drdy_sync[i-1];
        r_dout_sync[i] <= r_dout_sync[i-1];
      end
      r_sclk_prev <= w_sclk_s;
      r_drdy_prev <= w_drdy_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e            r_state;
  state_e            w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_next;
  logic [DW-1:0]     r_shift;
  logic [DW-1:0]     w_shift_next;
  logic              w_frame_done;
  logic              w_frame_err_set;
  logic              w_start;

  // State, bit counter and shift register
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
    end
  end

  // Next-state logic; disable overrides everything and abandons a partial frame
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_shift_next    = r_shift;
    w_frame_done    = 1'b0;
    w_frame_err_set = 1'b0;
    w_start         = 1'b0;
    if (!en) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          w_state_next = StWaitDrdy;
          w_start      = 1'b1;
        end
        StWaitDrdy: begin
          if (w_drdy_rise) begin
            w_state_next = StShift;
            w_cnt_next   = '0;
            w_shift_next = '0;
          end
        end
        StShift: begin
          if (r_cnt == CntW'(DW)) begin
            w_frame_done = 1'b1;
            // A DRDY edge coinciding with completion starts the next frame directly
            if (w_drdy_rise) begin
              w_state_next = StShift;
              w_cnt_next   = '0;
              w_shift_next = '0;
            end else begin
              w_state_next = StWaitDrdy;
            end
          end else if (w_drdy_rise) begin
            w_frame_err_set = 1'b1;
            w_cnt_next      = '0;
            w_shift_next    = '0;
          end else if (w_sclk_fall) begin
            w_shift_next = {r_shift[DW-2:0], w_dout_s};
            w_cnt_next   = r_cnt + CntW'(1);
          end
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Startup discard and sticky flags
  // ---------------------------------------------------------------------------
  logic [DiscW-1:0] r_disc_cnt;
  logic             r_discarding;
  logic             r_overflow;
  logic             r_frame_err;
  logic             w_discard_frame;
  logic             w_push_req;
  logic             w_full;

  assign w_discard_frame = (32'(r_disc_cnt) < DISCARD);
  assign w_push_req      = w_frame_done & ~w_discard_frame;

  // Discard counter, discarding indicator and sticky error flags
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_disc_cnt   <= '0;
      r_discarding <= 1'b1;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_disc_cnt   <= '0;
        r_discarding <= (DISCARD != 0);
      end else if (w_frame_done) begin
        if (w_discard_frame) begin
          r_disc_cnt <= r_disc_cnt + DiscW'(1);
          if ((32'(r_disc_cnt) + 32'd1) == DISCARD) begin
            r_discarding <= 1'b0;
          end
        end else begin
          r_discarding <= 1'b0;
        end
      end
      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_frame_err_set) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;
  assign discarding = r_discarding;

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through, registered head)
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_tvalid;
  logic [OUT_W-1:0] r_tdata;
  logic             w_pop;
  logic             w_push;
  logic [AW:0]      w_count_next;
  logic [AW-1:0]    w_rptr_next;
  logic [OUT_W-1:0] w_word;
  logic [OUT_W-1:0] w_head_next;

  assign w_word = {{ExtW{r_shift[DW-1]}}, r_shift};

  // Push/pop decisions and the head word presented after this edge
  always_comb begin
    w_pop        = r_tvalid & m_axis.m_axis_tready;
    // A same-cycle pop frees a slot, so full-with-pop still accepts the push
    w_full       = (r_count == (AW+1)'(FIFO_DEPTH)) && !w_pop;
    w_push       = w_push_req & ~w_full;
    w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_rptr_next  = r_rptr + AW'(w_pop);
    w_head_next  = '0;
    if (w_count_next != '0) begin
      if ((r_count - (AW+1)'(w_pop)) == '0) begin
        w_head_next = w_word;
      end else begin
        w_head_next = r_mem[w_rptr_next];
      end
    end
  end

  // FIFO pointers, occupancy and registered output stage
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr   <= w_rptr_next;
      r_count  <= w_count_next;
      r_tvalid <= (w_count_next != '0);
      r_tdata  <= w_head_next;
    end
  end

  // FIFO storage; pointers alone define occupancy, so no reset is needed
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  assign m_axis.m_axis_tvalid = r_tvalid;
  assign m_axis.m_axis_tdata  = r_tdata;

endmodule

// File: tb/tb_ads1675_frame_rx.sv
// Bench for ads1675_frame_rx: drives ADS1675-style serial frames with random
// SCLK timing and data, and checks the output stream against a queue model.
module tb_ads1675_frame_rx;

  localparam int unsigned DISCARD = 2;
  localparam int unsigned DEPTH   = 4;

  logic aclk     = 1'b0;
  logic areset_n = 1'b0;
  logic en       = 1'b0;
  logic sclk     = 1'b0;
  logic dout     = 1'b0;
  logic drdy     = 1'b0;
  logic overflow;
  logic frame_err;
  logic discarding;

  ads1675_frame_rx_if #(.OUT_W(32)) axis ();

  ads1675_frame_rx #(
    .DW         (24),
    .OUT_W      (32),
    .SYNC_STAGES(2),
    .DISCARD    (DISCARD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .en        (en),
    .sclk      (sclk),
    .dout      (dout),
    .drdy      (drdy),
    .m_axis    (axis.master),
    .overflow  (overflow),
    .frame_err (frame_err),
    .discarding(discarding)
  );

  always #5 aclk = ~aclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          disc_cnt     = 0;
  int          pushed_total = 0;
  int          got_total    = 0;
  logic        exp_ovf      = 1'b0;
  logic        exp_ferr     = 1'b0;

  // Collect every accepted beat (tready only changes just after posedge)
  always @(negedge aclk) begin
    if (areset_n && axis.m_axis_tvalid && axis.m_axis_tready) begin
      got_q.push_back(axis.m_axis_tdata);
      got_total++;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge aclk);
    #1;
  endtask

  task automatic wait_pos(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Reference model: one call per frame the ADC delivered completely
  task automatic model_frame(input logic [23:0] w);
    logic signed [31:0] s;
    s = $signed(w);
    if (disc_cnt < int'(DISCARD)) begin
      disc_cnt++;
    end else if ((pushed_total - got_total) >= int'(DEPTH)) begin
      exp_ovf = 1'b1;
    end else begin
      exp_q.push_back(s);
      pushed_total++;
    end
  endtask

  task automatic model_restart();
    disc_cnt = 0;
  endtask

  // DRDY pulse then nbits MSB-first; returns right after the last SCLK fall
  task automatic send_bits(input logic [23:0] w, input int nbits);
    int h;
    drdy = 1'b1;
    wait_neg(2);
    drdy = 1'b0;
    wait_neg(2);
    for (int i = 0; i < nbits; i++) begin
      h = int'($urandom_range(4, 2));
      sclk = 1'b1;
      dout = w[23-i];
      wait_neg(h);
      sclk = 1'b0;
      if (i < nbits - 1) wait_neg(h);
    end
  endtask

  task automatic send_frame(input logic [23:0] w);
    send_bits(w, 24);
    wait_neg(8);
    model_frame(w);
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    en = 1'b0;
    axis.m_axis_tready = 1'b0;
    wait_pos(3);
    n_tests++;
    if (axis.m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tvalid got %b exp 0", axis.m_axis_tvalid);
    end
    n_tests++;
    if (axis.m_axis_tdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_tdata got %h exp 0", axis.m_axis_tdata);
    end
    n_tests++;
    if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got ovf=%b ferr=%b exp 0/0", overflow, frame_err);
    end
    n_tests++;
    if (discarding !== 1'b1) begin
      n_fail++; $display("FAIL reset_discarding got %b exp 1", discarding);
    end
    areset_n = 1'b1;
    wait_pos(2);
  endtask

  task automatic test_discard();
    logic [31:0] e;
    logic [31:0] g;
    en = 1'b1;
    axis.m_axis_tready = 1'b1;
    model_restart();
    wait_pos(3);
    send_frame(24'h123456);
    n_tests++;
    if (discarding !== 1'b1) begin
      n_fail++; $display("FAIL discard_after1 got %b exp 1", discarding);
    end
    send_frame(24'h800001);
    n_tests++;
    if (discarding !== 1'b0) begin
      n_fail++; $display("FAIL discard_after2 got %b exp 0", discarding);
    end
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL discard_no_output got %0d words exp 0", got_q.size());
    end
    send_frame(24'h7FFFFF);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL discard_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL discard_data got %h exp %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
    n_tests++;
    if (overflow !== exp_ovf || frame_err !== exp_ferr) begin
      n_fail++; $display("FAIL discard_flags got %b/%b exp %b/%b", overflow, frame_err,
                         exp_ovf, exp_ferr);
    end
  endtask

  task automatic test_latency();
    logic [23:0] w;
    logic [31:0] e;
    logic [31:0] g;
    w = 24'($urandom());
    send_bits(w, 24);
    for (int k = 1; k <= 4; k++) begin
      wait_neg(1);
      n_tests++;
      if (axis.m_axis_tvalid !== (k == 4)) begin
        n_fail++; $display("FAIL latency_c%0d got tvalid=%b exp %b", k, axis.m_axis_tvalid,
                           (k == 4));
      end
    end
    wait_neg(6);
    model_frame(w);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL latency_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL latency_data got %h exp %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_sign_ext();
    logic [23:0] fixed [4];
    logic [31:0] e;
    logic [31:0] g;
    fixed[0] = 24'hFFFFFF; fixed[1] = 24'h000001;
    fixed[2] = 24'hABCDEF; fixed[3] = 24'h000000;
    for (int i = 0; i < 4; i++) send_frame(fixed[i]);
    for (int i = 0; i < 4; i++) send_frame(24'($urandom()));
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL signext_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL signext_data got %h exp %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    logic [31:0] g;
    bit          done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_frame(24'($urandom()));
        done = 1'b1;
      end
      begin
        logic        prev_stall;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (!done) begin
          @(posedge aclk); #1;
          axis.m_axis_tready = 1'($urandom_range(1, 0));
          @(negedge aclk);
          if (prev_stall) begin
            n_tests++;
            if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== prev_data) begin
              n_fail++; $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h",
                                 axis.m_axis_tvalid, axis.m_axis_tdata, prev_data);
            end
          end
          prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
          prev_data  = axis.m_axis_tdata;
        end
      end
    join
    wait_pos(1);
    axis.m_axis_tready = 1'b1;
    wait_pos(8);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL bp_data got %h exp %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    logic [31:0] g;
    wait_pos(1);
    axis.m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_frame(24'($urandom()));
    n_tests++;
    if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag got %b exp 1 (model %b)", overflow, exp_ovf);
    end
    n_tests++;
    if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== exp_q[0]) begin
      n_fail++; $display("FAIL ovf_head got v=%b d=%h exp v=1 d=%h", axis.m_axis_tvalid,
                         axis.m_axis_tdata, exp_q[0]);
    end
    wait_pos(1);
    axis.m_axis_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      n_tests++;
      if (axis.m_axis_tvalid !== (k < 4)) begin
        n_fail++; $display("FAIL ovf_drain_c%0d got tvalid=%b exp %b", k, axis.m_axis_tvalid,
                           (k < 4));
      end
    end
    wait_pos(2);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL ovf_data got %h exp %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_err();
    logic [31:0] e;
    logic [31:0] g;
    send_bits(24'($urandom()), 10);
    wait_neg(6);
    n_tests++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL ferr_early got %b exp 0", frame_err);
    end
    exp_ferr = 1'b1;
    send_frame(24'h0000AA);
    n_tests++;
    if (frame_err !== exp_ferr) begin
      n_fail++; $display("FAIL ferr_flag got %b exp %b", frame_err, exp_ferr);
    end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ferr_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL ferr_data got %h exp %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_en_drop();
    logic [31:0] e;
    logic [31:0] g;
    send_bits(24'($urandom()), 12);
    wait_pos(2);
    en = 1'b0;
    wait_pos(3);
    en = 1'b1;
    model_restart();
    wait_pos(3);
    n_tests++;
    if (discarding !== 1'b1) begin
      n_fail++; $display("FAIL endrop_discarding got %b exp 1", discarding);
    end
    for (int i = 0; i < 3; i++) send_frame(24'($urandom()));
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL endrop_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL endrop_data got %h exp %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
    n_tests++;
    if (overflow !== exp_ovf || frame_err !== exp_ferr) begin
      n_fail++; $display("FAIL endrop_flags got %b/%b exp %b/%b", overflow, frame_err,
                         exp_ovf, exp_ferr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    logic [31:0] g;
    wait_pos(1);
    axis.m_axis_tready = 1'b0;
    for (int i = 0; i < 2; i++) send_frame(24'($urandom()));
    send_bits(24'($urandom()), 12);
    wait_pos(1);
    areset_n = 1'b0;
    wait_pos(1);
    n_tests++;
    if (axis.m_axis_tvalid !== 1'b0 || axis.m_axis_tdata !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_out got v=%b d=%h exp 0/0", axis.m_axis_tvalid,
                         axis.m_axis_tdata);
    end
    n_tests++;
    if (overflow !== 1'b0 || frame_err !== 1'b0 || discarding !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_flags got ovf=%b ferr=%b disc=%b exp 0/0/1", overflow,
                         frame_err, discarding);
    end
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_leak got %0d words exp 0", got_q.size());
    end
    exp_q.delete(); got_q.delete();
    pushed_total = got_total;
    exp_ovf = 1'b0; exp_ferr = 1'b0;
    model_restart();
    areset_n = 1'b1;
    axis.m_axis_tready = 1'b1;
    wait_pos(3);
    for (int i = 0; i < 3; i++) send_frame(24'($urandom()));
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++; $display("FAIL rstmid_data got %h exp %h", g, e);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    axis.m_axis_tready = 1'b0;
    test_reset();
    test_discard();
    test_latency();
    test_sign_ext();
    test_backpressure();
    test_overflow();
    test_frame_err();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge aclk);
    $display("FAIL watchdog expired after 90000 cycles");
    $fatal(1);
  end

endmodule
